// File: rtl/gcd_core.sv
// -----------------------------------------------------------------------------
// gcd_core
//   Iterative subtract-based Euclid GCD unit. A Go strobe loads X/Y into the
//   working registers A/B. After that the unit performs one subtraction per
//   clock until A==B (or one side is zero). It then raises Done and holds the
//   result in A and B.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (state=IDLE, A=B=0, Done=0)
//   X, Y   in   unsigned operands, sampled only on the load edge
//   Go     in   start request; ignored while a computation is running
//   Done   out  registered result-valid level, high in DONE until next Go
//   A, B   out  working registers; both hold gcd(X,Y) when Done=1
// -----------------------------------------------------------------------------
module gcd_core #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Go,
    output logic             Done,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Datapath comparisons used by the RUN priority chain.
    logic a_eq_b;
    logic a_zero;
    logic b_zero;
    logic a_gt_b;

    assign a_eq_b = (A == B);
    assign a_zero = (A == '0);
    assign b_zero = (B == '0);
    assign a_gt_b = (A > B);

    // Single FSM process. Controller and datapath registers share it, so
    // A, B and Done are always registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            A     <= '0;
            B     <= '0;
            Done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Go) begin
                        A     <= X;
                        B     <= Y;
                        Done  <= 1'b0;
                        state <= RUN;
                    end
                end

                RUN: begin
                    // Equality is tested first, so (0,0) terminates with result 0.
                    // Zero tests come before the subtractions. When exactly one
                    // side is zero, the other side already holds the GCD.
                    if (a_eq_b) begin
                        Done  <= 1'b1;
                        state <= DONE;
                    end else if (a_zero) begin
                        A     <= B;
                        Done  <= 1'b1;
                        state <= DONE;
                    end else if (b_zero) begin
                        B     <= A;
                        Done  <= 1'b1;
                        state <= DONE;
                    end else if (a_gt_b) begin
                        // The branch condition guarantees no underflow.
                        A <= A - B;
                    end else begin
                        B <= B - A;
                    end
                end

                DONE: begin
                    // A back-to-back start reloads directly without visiting IDLE.
                    if (Go) begin
                        A     <= X;
                        B     <= Y;
                        Done  <= 1'b0;
                        state <= RUN;
                    end
                end

                default: begin
                    state <= IDLE;
                    A     <= '0;
                    B     <= '0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_core.sv
// -----------------------------------------------------------------------------
// tb_gcd_core
//   Scoreboard bench for gcd_core. Each start pushes the expected result and
//   the edge after which Done must rise. The model computes these with
//   modulo-form Euclid: the subtraction count is the sum of the quotients
//   minus one. A monitor pops one entry on every Done rising edge.
// -----------------------------------------------------------------------------
module tb_gcd_core;

    localparam int WIDTH = 5;

    typedef struct {
        int gcd;
        int done_edge;
        int x;
        int y;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             Go;
    logic             Done;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    gcd_core #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .X    (X),
        .Y    (Y),
        .Go   (Go),
        .Done (Done),
        .A    (A),
        .B    (B)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges; edge N is the N-th posedge.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the GCD and the number of subtractions the
    // subtract-form Euclid needs, derived from the quotient sum.
    function automatic int ref_gcd(input int a, input int b);
        int x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int ref_subs(input int a, input int b);
        int x, y, t, s;
        if (a == 0 || b == 0) return 0;
        x = a;
        y = b;
        s = 0;
        while (y != 0) begin
            s += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        return s - 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive Go for one cycle at the negedge before the load edge. After the
    // load edge, X/Y are scrambled to show they are not sampled again.
    task automatic start(input int x, input int y, input bit push);
        exp_t e;
        @(negedge clk);
        X  = WIDTH'(x);
        Y  = WIDTH'(y);
        Go = 1'b1;
        if (push) begin
            e.gcd       = ref_gcd(x, y);
            e.done_edge = cyc + 1 + 1 + ref_subs(x, y);
            e.x         = x;
            e.y         = y;
            sb.push_back(e);
        end
        @(negedge clk);
        Go = 1'b0;
        X  = WIDTH'($urandom);
        Y  = WIDTH'($urandom);
    endtask

    // Bounded wait for the scoreboard to drain.
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d results still pending after %0d cycles", name, sb.size(), n);
            sb.delete();
        end
    endtask

    // Monitor: on each Done rising edge, pop and compare the result and timing.
    initial begin
        bit   done_q;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (Done && !done_q) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: Done rose with A=%0d B=%0d but nothing was pending", A, B);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("gcd_A(%0d,%0d)", e.x, e.y), int'(A), e.gcd);
                    chk($sformatf("gcd_B(%0d,%0d)", e.x, e.y), int'(B), e.gcd);
                    chk($sformatf("done_edge(%0d,%0d)", e.x, e.y), cyc, e.done_edge);
                end
            end
            done_q = Done;
        end
    end

    initial begin
        int ld;
        rst_n = 1'b0;
        Go    = 1'($urandom);
        X     = WIDTH'($urandom);
        Y     = WIDTH'($urandom);
        #1;
        chk("reset_A", int'(A), 0);
        chk("reset_B", int'(B), 0);
        chk("reset_Done", int'(Done), 0);
        #12;
        Go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold_A", int'(A), 0);
        chk("idle_hold_B", int'(B), 0);
        chk("idle_hold_Done", int'(Done), 0);

        // Directed trace of the (12,8) case.
        @(negedge clk);
        X  = 5'd12;
        Y  = 5'd8;
        Go = 1'b1;
        begin
            exp_t e;
            e.gcd = 4;
            e.done_edge = cyc + 4;
            e.x = 12;
            e.y = 8;
            sb.push_back(e);
        end
        @(negedge clk);
        Go = 1'b0;
        chk("trace1_A", int'(A), 12);
        chk("trace1_B", int'(B), 8);
        @(negedge clk);
        chk("trace2_A", int'(A), 4);
        chk("trace2_B", int'(B), 8);
        @(negedge clk);
        chk("trace3_A", int'(A), 4);
        chk("trace3_B", int'(B), 4);
        wait_drain("12_8");
        repeat (3) @(negedge clk);
        chk("hold_Done", int'(Done), 1);
        chk("hold_A", int'(A), 4);
        chk("hold_B", int'(B), 4);

        // Zero and equal operands.
        start(0, 9, 1);   wait_drain("0_9");
        start(7, 0, 1);   wait_drain("7_0");
        start(0, 0, 1);   wait_drain("0_0");
        start(13, 13, 1); wait_drain("13_13");

        // Worst case; the monitor checks that Done rises after edge 32.
        start(31, 1, 1);  wait_drain("31_1");
        start(1, 31, 1);  wait_drain("1_31");

        // Coprime operands, then a back-to-back restart from DONE.
        start(21, 13, 1); wait_drain("21_13");
        start(18, 24, 1);
        chk("restart_Done_drop", int'(Done), 0);
        chk("restart_A", int'(A), 18);
        chk("restart_B", int'(B), 24);
        wait_drain("18_24");

        // Go pulsed mid-run must be ignored; the timing check covers this too.
        start(21, 13, 1);
        @(negedge clk);
        X  = 5'd5;
        Y  = 5'd5;
        Go = 1'b1;
        @(negedge clk);
        Go = 1'b0;
        wait_drain("go_ignored");

        // Reset mid-run aborts immediately.
        start(31, 1, 0);
        ld = cyc;
        while (cyc < ld + 9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_A", int'(A), 0);
        chk("midrst_B", int'(B), 0);
        chk("midrst_Done", int'(Done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start(10, 4, 1);
        wait_drain("10_4");

        // Randomized operands.
        for (int i = 0; i < 25; i++) begin
            start(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1);
            wait_drain("random");
        end

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
